// File: rtl/attack_stage_pkg.sv
// Shared ADSR definitions: default widths and attack FSM state encoding.
package attack_stage_pkg;

    localparam int ADSR_DATA_W    = 20;
    localparam int ADSR_SHIFT_W   = 5;
    localparam int ADSR_MAX_SHIFT = 20;
    localparam int ADSR_DIV_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/attack_stage_if.sv
// Control/sample bundle between the envelope controller and the attack stage.
interface attack_stage_if #(
    parameter int DATA_W = 20,
    parameter int DIV_W  = 16
);

    logic              i_start;
    logic              i_stop;
    logic [DIV_W-1:0]  i_rate_div;
    logic [DATA_W-1:0] i_in;
    logic [DATA_W-1:0] o_out;
    logic              o_busy;
    logic              o_end_attack;

    modport master (
        output i_start,
        output i_stop,
        output i_rate_div,
        output i_in,
        input  o_out,
        input  o_busy,
        input  o_end_attack
    );

    modport slave (
        input  i_start,
        input  i_stop,
        input  i_rate_div,
        input  i_in,
        output o_out,
        output o_busy,
        output o_end_attack
    );

endinterface

// File: rtl/attack_stage_rate_ticker.sv
// Rate prescaler: counts up to i_div and emits a 1-cycle tick on the match.
module rate_ticker #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit  = (r_cnt == i_div);
    assign o_tick = i_en & w_hit;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/attack_stage.sv
// ADSR attack stage: ramps attenuation from MAX_SHIFT down to 0 at a set rate.
module attack_stage
    import attack_stage_pkg::*;
#(
    parameter int DATA_W    = ADSR_DATA_W,
    parameter int SHIFT_W   = ADSR_SHIFT_W,
    parameter int MAX_SHIFT = ADSR_MAX_SHIFT,
    parameter int DIV_W     = ADSR_DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    attack_stage_if.slave  bus
);

    localparam logic [SHIFT_W-1:0] W_MAX = SHIFT_W'(MAX_SHIFT);
    localparam logic [SHIFT_W-1:0] W_ONE = SHIFT_W'(1);

    state_t             r_state;
    state_t             w_state_nx;
    logic [SHIFT_W-1:0] r_shift;
    logic [SHIFT_W-1:0] w_shift_nx;
    logic [DIV_W-1:0]   r_div_q;
    logic [DIV_W-1:0]   w_div_nx;
    logic [DATA_W-1:0]  r_out;
    logic               w_tick;
    logic               w_clr;
    logic               w_en;

    // Counter restarts on any retrigger/abort and only runs while ramping.
    assign w_en  = (r_state == ST_RAMP);
    assign w_clr = bus.i_start | bus.i_stop | ~w_en;

    rate_ticker #(
        .DIV_W (DIV_W)
    ) u_ticker (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_div  (r_div_q),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_div_nx   = r_div_q;
        if (bus.i_start) begin
            w_state_nx = ST_RAMP;
            w_shift_nx = W_MAX;
            w_div_nx   = bus.i_rate_div;
        end else if (bus.i_stop) begin
            w_state_nx = ST_IDLE;
            w_shift_nx = W_MAX;
        end else begin
            case (r_state)
                ST_IDLE: w_shift_nx = W_MAX;
                ST_RAMP: begin
                    if (w_tick) begin
                        w_shift_nx = r_shift - 1'b1;
                        if (r_shift == W_ONE) begin
                            w_state_nx = ST_DONE;
                        end
                    end
                end
                ST_DONE: w_shift_nx = '0;
                default: begin
                    w_state_nx = ST_IDLE;
                    w_shift_nx = W_MAX;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= W_MAX;
            r_div_q <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_div_q <= w_div_nx;
            r_out   <= bus.i_in >> r_shift;
        end
    end

    assign bus.o_out        = r_out;
    assign bus.o_busy       = (r_state == ST_RAMP);
    assign bus.o_end_attack = (r_state == ST_DONE);

endmodule

// File: tb/tb_attack_stage.sv
// Testbench for attack_stage: elapsed-time envelope model plus literal pins.
module tb_attack_stage;

    localparam int DW  = 20;
    localparam int VW  = 16;
    localparam int MAX = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    attack_stage_if #(.DATA_W(DW), .DIV_W(VW)) ifc ();

    attack_stage #(
        .DATA_W    (DW),
        .SHIFT_W   (5),
        .MAX_SHIFT (MAX),
        .DIV_W     (VW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc_n  = 0;

    // Model: 0 idle, 1 ramping, 2 done; j = edges since the start edge.
    int          m_mode  = 0;
    int          m_j     = 0;
    int          m_d     = 0;
    bit          m_valid = 1'b0;
    logic [DW-1:0] m_out = '0;
    int          start_cyc = 0;
    int          rise_cyc  = 0;
    bit          prev_end  = 1'b0;

    function automatic int m_shift();
        if (m_mode == 0) return MAX;
        if (m_mode == 2) return 0;
        return MAX - m_j / (m_d + 1);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc_n);
        end
    endtask

    always @(posedge clk) begin
        cyc_n++;
        if (rst) begin
            m_mode  = 0;
            m_out   = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_out = ifc.i_in >> m_shift();
            if (ifc.i_start) begin
                m_mode    = 1;
                m_j       = 0;
                m_d       = int'(ifc.i_rate_div);
                start_cyc = cyc_n;
            end else if (ifc.i_stop) begin
                m_mode = 0;
            end else if (m_mode == 1) begin
                m_j++;
                if (m_j / (m_d + 1) >= MAX) m_mode = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("out", 32'(ifc.o_out), 32'(m_out));
            chk("busy", 32'(ifc.o_busy), 32'(m_mode == 1));
            chk("end_attack", 32'(ifc.o_end_attack), 32'(m_mode == 2));
            if (ifc.o_end_attack && !prev_end) rise_cyc = cyc_n;
            prev_end = ifc.o_end_attack;
        end
    end

    task automatic tick(bit st, bit sp, logic [VW-1:0] rd,
                        logic [DW-1:0] din, bit r);
        @(negedge clk);
        ifc.i_start    = st;
        ifc.i_stop     = sp;
        ifc.i_rate_div = rd;
        ifc.i_in       = din;
        rst            = r;
    endtask

    task automatic wait_end(int budget, logic [VW-1:0] rd, logic [DW-1:0] din);
        for (int i = 0; i < budget && !ifc.o_end_attack; i++) begin
            tick(1'b0, 1'b0, rd, din, 1'b0);
        end
        #1;
        chk("end_timeout", 32'(ifc.o_end_attack), 32'd1);
    endtask

    initial begin
        ifc.i_start    = 1'b0;
        ifc.i_stop     = 1'b0;
        ifc.i_rate_div = '0;
        ifc.i_in       = 20'hFFFFF;

        // Reset for 3 cycles
        repeat (3) tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b1);
        tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        #1;
        chk("rst_out", 32'(ifc.o_out), 32'd0);
        chk("rst_busy", 32'(ifc.o_busy), 32'd0);
        chk("rst_end", 32'(ifc.o_end_attack), 32'd0);

        // One step per clock
        tick(1'b1, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        wait_end(100, 16'd0, 20'hFFFFF);
        chk("t2_rise", 32'(rise_cyc - start_cyc), 32'd20);
        tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        #1;
        chk("t2_full", 32'(ifc.o_out), 32'hFFFFF);

        // Four cycles per step, rate_div changed mid-ramp
        tick(1'b1, 1'b0, 16'd3, 20'hFFFFF, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 16'd3, 20'hFFFFF, 1'b0);
        repeat (10) tick(1'b0, 1'b0, VW'($urandom), 20'hFFFFF, 1'b0);
        wait_end(200, 16'd0, 20'hFFFFF);
        chk("t3_rise", 32'(rise_cyc - start_cyc), 32'd80);

        // Retrigger at shift=7
        tick(1'b1, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        repeat (13) tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        tick(1'b1, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        #1;
        chk("t4_busy", 32'(ifc.o_busy), 32'd1);
        chk("t4_out7", 32'(ifc.o_out), 32'h01FFF);
        wait_end(100, 16'd0, 20'hFFFFF);
        tick(1'b1, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        #1;
        chk("t4_end_drop", 32'(ifc.o_end_attack), 32'd0);
        chk("t4_rebusy", 32'(ifc.o_busy), 32'd1);

        // Stop at shift=10, then start+stop together
        tick(1'b1, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        tick(1'b0, 1'b1, 16'd0, 20'hFFFFF, 1'b0);
        tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        #1;
        chk("t5_busy", 32'(ifc.o_busy), 32'd0);
        chk("t5_out10", 32'(ifc.o_out), 32'h003FF);
        tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        #1;
        chk("t5_out0", 32'(ifc.o_out), 32'd0);
        tick(1'b1, 1'b1, 16'd0, 20'hFFFFF, 1'b0);
        tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        #1;
        chk("t5_both", 32'(ifc.o_busy), 32'd1);

        // Reset mid-ramp
        repeat (4) tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b1);
        tick(1'b0, 1'b0, 16'd0, 20'hFFFFF, 1'b0);
        #1;
        chk("t6_out", 32'(ifc.o_out), 32'd0);
        chk("t6_busy", 32'(ifc.o_busy), 32'd0);
        chk("t6_end", 32'(ifc.o_end_attack), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 24) == 0,
                 $urandom_range(0, 59) == 0,
                 VW'($urandom_range(0, 3)),
                 DW'($urandom),
                 $urandom_range(0, 149) == 0);
        end
        tick(1'b0, 1'b0, 16'd0, 20'h0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
